// File: rtl/plic_gateway_pkg.sv
// Shared definitions for the PLIC interrupt gateway: default source count and the
// per-source edge-request FSM encoding.
package plic_gateway_pkg;

  localparam int PLIC_N_INT_SRC = 32;

  typedef enum logic [1:0] {
    GW_IDLE   = 2'd0,
    GW_ACTIVE = 2'd1,
    GW_GAP    = 2'd2
  } gw_state_e;

endpackage

// File: rtl/plic_gateway_src.sv
// One interrupt source: synchroniser, polarity, edge detect, edge counter with sticky
// overflow, and the request FSM that drops the request for one cycle after each claim.
module plic_gateway_src
  import plic_gateway_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int W_CNT       = 4,
  parameter bit EDGE        = 1'b0,
  parameter bit POL         = 1'b0
) (
  input  logic CLK,
  input  logic RST_X,
  input  logic irq,
  input  logic ack,
  input  logic ovf_clr,
  output logic int_src,
  output logic ovf
);

  localparam logic [W_CNT-1:0] CNT_MAX = '1;
  localparam logic [W_CNT-1:0] CNT_ONE = {{(W_CNT-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_p;
  logic [SYNC_STAGES:0]   vld_p;
  logic                   s;
  logic                   s_d;
  logic                   sync_vld;
  logic                   armed;

  // Saturating edge counter step; the top bit of the result flags an edge lost at max.
  function automatic logic [W_CNT:0] cnt_update(input logic [W_CNT-1:0] c,
                                                input logic inc,
                                                input logic dec);
    logic [W_CNT:0] r;
    r = {1'b0, c};
    if (inc && !dec) begin
      if (c == CNT_MAX) r = {1'b1, c};
      else              r = {1'b0, c + CNT_ONE};
    end else if (dec && !inc) begin
      r = {1'b0, c - CNT_ONE};
    end
    return r;
  endfunction

  // Synchroniser stage; vld_p marks which stages hold samples taken after reset.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      sync_p <= '0;
      vld_p  <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], irq};
      vld_p  <= {vld_p[SYNC_STAGES-1:0], 1'b1};
      s_d    <= s & sync_vld;
    end
  end

  assign s        = sync_p[SYNC_STAGES-1] ^ POL;
  assign sync_vld = vld_p[SYNC_STAGES-1];
  // A line already active across reset release is a level, not a fresh edge.
  assign armed    = vld_p[SYNC_STAGES];

  if (EDGE) begin : g_edge
    logic [W_CNT-1:0] cnt;
    logic [W_CNT-1:0] cnt_next;
    logic             ovf_set;
    logic             rise;
    logic             dec;
    logic             ovf_q;
    logic             int_q;
    gw_state_e        state;

    assign rise = armed & s & ~s_d;
    assign dec  = ack & (cnt != '0);

    always_comb begin
      {ovf_set, cnt_next} = cnt_update(cnt, rise, dec);
    end

    // Counter / request FSM stage.
    always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
        cnt   <= '0;
        ovf_q <= 1'b0;
        state <= GW_IDLE;
        int_q <= 1'b0;
      end else begin
        cnt   <= cnt_next;
        ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
        case (state)
          GW_IDLE: begin
            if (cnt_next != '0) begin
              state <= GW_ACTIVE;
              int_q <= 1'b1;
            end
          end
          GW_ACTIVE: begin
            if (ack) begin
              state <= GW_GAP;
              int_q <= 1'b0;
            end
          end
          GW_GAP: begin
            if (cnt_next != '0) begin
              state <= GW_ACTIVE;
              int_q <= 1'b1;
            end else begin
              state <= GW_IDLE;
              int_q <= 1'b0;
            end
          end
          default: begin
            state <= GW_IDLE;
            int_q <= 1'b0;
          end
        endcase
      end
    end

    assign int_src = int_q;
    assign ovf     = ovf_q;
  end else begin : g_level
    logic unused_lvl;
    assign unused_lvl = ^{ack, ovf_clr, armed};
    assign int_src    = s_d;
    assign ovf        = 1'b0;
  end

endmodule

// File: rtl/plic_gateway.sv
// Interrupt gateway in front of the PLIC: one conditioning slice per source, with
// edge/level and polarity selected per bit by the mask parameters.
module plic_gateway
  import plic_gateway_pkg::*;
#(
  parameter int                   N_INT_SRC   = PLIC_N_INT_SRC,
  parameter int                   SYNC_STAGES = 2,
  parameter int                   W_CNT       = 4,
  parameter logic [N_INT_SRC-1:0] EDGE_MASK   = '0,
  parameter logic [N_INT_SRC-1:0] POL_MASK    = '0
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic [N_INT_SRC-1:0] w_irq_in,
  input  logic [N_INT_SRC-1:0] w_int_ack,
  input  logic [N_INT_SRC-1:0] w_ovf_clr,
  output logic [N_INT_SRC-1:0] w_int_src,
  output logic [N_INT_SRC-1:0] w_ovf
);

  for (genvar i = 0; i < N_INT_SRC; i++) begin : g_src
    plic_gateway_src #(
      .SYNC_STAGES (SYNC_STAGES),
      .W_CNT       (W_CNT),
      .EDGE        (EDGE_MASK[i]),
      .POL         (POL_MASK[i])
    ) u_src (
      .CLK     (CLK),
      .RST_X   (RST_X),
      .irq     (w_irq_in[i]),
      .ack     (w_int_ack[i]),
      .ovf_clr (w_ovf_clr[i]),
      .int_src (w_int_src[i]),
      .ovf     (w_ovf[i])
    );
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: directed pin/claim sequences, a per-source request model
// compared every cycle, and literal expectations at the interesting points.
module tb_plic_gateway;

  localparam int             N     = 8;
  localparam int             SYNC  = 2;
  localparam int             WC    = 4;
  localparam int             CMAX  = 15;
  localparam logic [N-1:0]   EDGE_M = 8'h0E;
  localparam logic [N-1:0]   POL_M  = 8'h18;

  logic         CLK = 1'b0;
  logic         RST_X = 1'b0;
  logic [N-1:0] w_irq_in = '1;
  logic [N-1:0] w_int_ack = '0;
  logic [N-1:0] w_ovf_clr = '0;
  logic [N-1:0] w_int_src;
  logic [N-1:0] w_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  plic_gateway #(
    .N_INT_SRC   (N),
    .SYNC_STAGES (SYNC),
    .W_CNT       (WC),
    .EDGE_MASK   (EDGE_M),
    .POL_MASK    (POL_M)
  ) dut (
    .CLK       (CLK),
    .RST_X     (RST_X),
    .w_irq_in  (w_irq_in),
    .w_int_ack (w_int_ack),
    .w_ovf_clr (w_ovf_clr),
    .w_int_src (w_int_src),
    .w_ovf     (w_ovf)
  );

  always #5 CLK = ~CLK;

  // Model: history of active-sense pin samples since reset, queued edge count,
  // sticky overflow, and request shown to the PLIC.
  logic [N-1:0] hq [$];
  int           m_cnt [N] = '{default: 0};
  logic [N-1:0] m_out = '0;
  logic [N-1:0] m_ovf = '0;

  task automatic model_src(input int i, output int nc, output logic nout, output logic nf);
    int   e;
    logic lvl, ev, dec, set;
    e   = hq.size();
    lvl = (e - SYNC >= 1) ? hq[e-SYNC-1][i] : 1'b0;
    ev  = (e - SYNC >= 2) && hq[e-SYNC-1][i] && !hq[e-SYNC-2][i];
    nc  = m_cnt[i];
    nf  = m_ovf[i];
    if (!EDGE_M[i]) begin
      nout = lvl;
      nc   = 0;
      nf   = 1'b0;
    end else begin
      dec = w_int_ack[i] && (m_cnt[i] > 0);
      set = ev && !dec && (m_cnt[i] == CMAX);
      if (ev && !dec && m_cnt[i] < CMAX) nc = m_cnt[i] + 1;
      else if (dec && !ev)               nc = m_cnt[i] - 1;
      nf   = set ? 1'b1 : (w_ovf_clr[i] ? 1'b0 : m_ovf[i]);
      nout = m_out[i] ? !w_int_ack[i] : (nc > 0);
    end
  endtask

  always @(posedge CLK or negedge RST_X) begin : model
    int   nc;
    logic no, nf;
    if (!RST_X) begin
      hq.delete();
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
      m_out <= '0;
      m_ovf <= '0;
    end else begin
      hq.push_back(w_irq_in ^ POL_M);
      for (int i = 0; i < N; i++) begin
        model_src(i, nc, no, nf);
        m_cnt[i] <= nc;
        m_out[i] <= no;
        m_ovf[i] <= nf;
      end
    end
  end

  task automatic check(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    check("model_int_src", w_int_src, m_out);
    check("model_ovf", w_ovf, m_ovf);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_pin(input int i, input logic active);
    w_irq_in[i] = active ^ POL_M[i];
  endtask

  task automatic pulse_pin(input int i, input int hi, input int lo);
    set_pin(i, 1'b1);
    tick(hi);
    set_pin(i, 1'b0);
    tick(lo);
  endtask

  task automatic ack(input int i);
    w_int_ack[i] = 1'b1;
    tick(1);
    w_int_ack[i] = 1'b0;
  endtask

  task automatic clr(input int i);
    w_ovf_clr[i] = 1'b1;
    tick(1);
    w_ovf_clr[i] = 1'b0;
  endtask

  task automatic drain(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      check1("drain_active", w_int_src[i], 1'b1);
      ack(i);
      check1("drain_gap", w_int_src[i], 1'b0);
      tick(1);
    end
    check1("drain_idle", w_int_src[i], 1'b0);
  endtask

  initial begin
    // T1: reset with every pin high
    tick(3);
    check("t1_in_reset", w_int_src, 8'h00);
    check("t1_ovf_reset", w_ovf, 8'h00);
    RST_X = 1'b1;
    tick(2);
    check("t1_lat2", w_int_src, 8'h00);
    tick(1);
    check("t1_lat3", w_int_src, 8'hE1);
    check("t1_ovf", w_ovf, 8'h00);
    w_irq_in = POL_M;
    tick(6);
    check("t1_idle", w_int_src, 8'h00);

    // T2: level source 0 with ignored claim/clear
    set_pin(0, 1'b1);
    tick(2);
    check1("t2_lat2", w_int_src[0], 1'b0);
    tick(1);
    check1("t2_lat3", w_int_src[0], 1'b1);
    w_int_ack[0] = 1'b1;
    w_ovf_clr[0] = 1'b1;
    tick(1);
    w_int_ack[0] = 1'b0;
    w_ovf_clr[0] = 1'b0;
    tick(1);
    check1("t2_ack_ignored", w_int_src[0], 1'b1);
    check1("t2_no_ovf", w_ovf[0], 1'b0);
    set_pin(0, 1'b0);
    tick(2);
    check1("t2_fall_lat2", w_int_src[0], 1'b1);
    tick(1);
    check1("t2_fall_lat3", w_int_src[0], 1'b0);

    // T3: three rising pulses on src1, then three claims
    for (int k = 0; k < 3; k++) pulse_pin(1, 2, 2);
    tick(4);
    check1("t3_active", w_int_src[1], 1'b1);
    drain(1, 3);

    // T4: sixteen edges on src2 saturate the counter
    for (int k = 0; k < 15; k++) pulse_pin(2, 2, 2);
    tick(4);
    check1("t4_no_ovf_15", w_ovf[2], 1'b0);
    pulse_pin(2, 2, 2);
    check1("t4_ovf_16", w_ovf[2], 1'b1);
    clr(2);
    check1("t4_ovf_cleared", w_ovf[2], 1'b0);
    drain(2, 15);

    // T5a: edge and claim together at count 1
    pulse_pin(1, 2, 4);
    check1("t5a_active", w_int_src[1], 1'b1);
    set_pin(1, 1'b1);
    tick(2);
    ack(1);
    check1("t5a_gap", w_int_src[1], 1'b0);
    tick(1);
    check1("t5a_back", w_int_src[1], 1'b1);
    set_pin(1, 1'b0);
    tick(2);
    drain(1, 1);

    // T5b: edge and claim together at count max
    for (int k = 0; k < 15; k++) pulse_pin(2, 2, 2);
    check1("t5b_pre_ovf", w_ovf[2], 1'b0);
    set_pin(2, 1'b1);
    tick(2);
    ack(2);
    check1("t5b_no_ovf", w_ovf[2], 1'b0);
    set_pin(2, 1'b0);
    tick(2);

    // T5c: overflow set and clear in the same cycle
    set_pin(2, 1'b1);
    tick(2);
    clr(2);
    check1("t5c_set_wins", w_ovf[2], 1'b1);
    set_pin(2, 1'b0);
    tick(2);
    clr(2);
    check1("t5c_cleared", w_ovf[2], 1'b0);
    drain(2, 15);

    // T6: active-low src3, then reset with edges queued
    set_pin(3, 1'b1);
    tick(2);
    check1("t6_lat2", w_int_src[3], 1'b0);
    tick(1);
    check1("t6_lat3", w_int_src[3], 1'b1);
    set_pin(3, 1'b0);
    tick(2);
    for (int k = 0; k < 4; k++) pulse_pin(3, 2, 2);
    tick(2);
    check1("t6_queued", w_int_src[3], 1'b1);
    #2 RST_X = 1'b0;
    #1 check("t6_async_rst", w_int_src, 8'h00);
    check("t6_async_ovf", w_ovf, 8'h00);
    tick(1);
    RST_X = 1'b1;
    tick(10);
    check("t6_no_residual", w_int_src, 8'h00);
    ack(3);
    tick(2);
    check1("t6_still_idle", w_int_src[3], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
